// File: rtl/tdo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdo_sched_pkg
// Description : Shared types and width helpers for the TDO word scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tdo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 32;

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int id_w(input int nreq);
        return $clog2(nreq);
    endfunction

    localparam int CNT_W = cnt_w(WIDTH_DEF);
    localparam int ID_W  = id_w(NREQ_DEF);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching from ptr+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import tdo_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = id_w(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any_req
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        grant   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/tdo_word_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tdo_word_scheduler
// Description : Shares one serial TDO path between NREQ word sources.
// Revision    : 1.0 - initial release
// ============================================================================
module tdo_word_scheduler
    import tdo_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    word,
    input  logic                     shift_en,
    input  logic                     abort,
    output logic                     tdo,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int c_CNT_W = cnt_w(WIDTH);
    localparam int c_ID_W  = id_w(NREQ);

    state_t              r_state, w_state_n;
    logic [c_ID_W-1:0]   r_ptr, w_ptr_n;
    logic [c_ID_W-1:0]   w_gid_n;
    logic [WIDTH-1:0]    r_shreg, w_shreg_n;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_n;
    logic                w_tdo_n;
    logic [NREQ-1:0]     w_ack_n, w_done_n;
    logic [c_ID_W-1:0]   w_grant;
    logic                w_any_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (c_ID_W)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .any_req (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= c_ID_W'(NREQ - 1);
            grant_id <= '0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            tdo      <= 1'b0;
            ack      <= '0;
            done     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            grant_id <= w_gid_n;
            r_shreg  <= w_shreg_n;
            r_cnt    <= w_cnt_n;
            tdo      <= w_tdo_n;
            ack      <= w_ack_n;
            done     <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_gid_n   = grant_id;
        w_shreg_n = r_shreg;
        w_cnt_n   = r_cnt;
        w_tdo_n   = tdo;
        w_ack_n   = '0;
        w_done_n  = '0;
        case (r_state)
            ST_IDLE: begin
                if (!abort && w_any_req) begin
                    w_gid_n          = w_grant;
                    w_shreg_n        = word[w_grant*WIDTH +: WIDTH];
                    w_cnt_n          = c_CNT_W'(WIDTH);
                    w_ack_n[w_grant] = 1'b1;
                    w_state_n        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_n = ST_IDLE;
                end else if (shift_en) begin
                    w_tdo_n   = r_shreg[WIDTH-1];
                    w_shreg_n = {r_shreg[WIDTH-2:0], 1'b0};
                    w_cnt_n   = r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        w_state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // done appears as the machine re-enters IDLE; abort here cancels it
                if (abort) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_done_n[grant_id] = 1'b1;
                    w_ptr_n            = grant_id;
                    w_state_n          = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tdo_word_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdo_word_scheduler
// Description : Directed table-driven bench for tdo_word_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdo_word_scheduler;
    import tdo_sched_pkg::*;

    localparam int c_NREQ  = 4;
    localparam int c_WIDTH = 32;

    logic                       clk;
    logic                       reset;
    logic [c_NREQ-1:0]          req;
    logic [c_NREQ*c_WIDTH-1:0]  word;
    logic                       shift_en;
    logic                       abort;
    logic                       tdo;
    logic [c_NREQ-1:0]          ack;
    logic [c_NREQ-1:0]          done;
    logic                       busy;
    logic [ID_W-1:0]            grant_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   req;
        logic [127:0] word;
        int           period;
        bit           drop;
        logic [1:0]   eg;
        logic [31:0]  ed;
    } vec_t;

    vec_t tbl [8];

    tdo_word_scheduler #(
        .NREQ  (c_NREQ),
        .WIDTH (c_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .word     (word),
        .shift_en (shift_en),
        .abort    (abort),
        .tdo      (tdo),
        .ack      (ack),
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] ed, input int n);
        for (int i = 0; i < n; i++) begin
            shift_en = 1'b1;
            step();
            chk("tdo_bit", 32'(tdo), 32'(ed[31-i]));
        end
        shift_en = 1'b0;
    endtask

    // Grant from IDLE, shift the whole word, then expect the done pulse.
    task automatic run_xfer(input logic [3:0] r, input logic [127:0] w, input int period,
                            input bit drop, input logic [1:0] eg, input logic [31:0] ed);
        logic [3:0] exp1h;
        exp1h = 4'b0001 << eg;
        req   = r;
        word  = w;
        step();
        chk("ack", 32'(ack), 32'(exp1h));
        chk("grant_id", 32'(grant_id), 32'(eg));
        chk("busy_shift", 32'(busy), 32'd1);
        chk("done_at_ack", 32'(done), 32'd0);
        if (drop) begin
            req  = 4'b0000;
            word = ~w;
        end
        for (int b = 31; b >= 0; b--) begin
            shift_en = 1'b1;
            step();
            chk("tdo_bit", 32'(tdo), 32'(ed[b]));
            chk("pulses_quiet", 32'({ack, done}), 32'd0);
            if (b > 0) begin
                for (int g = 1; g < period; g++) begin
                    shift_en = 1'b0;
                    step();
                    chk("tdo_hold", 32'(tdo), 32'(ed[b]));
                end
            end
        end
        shift_en = 1'b1;
        chk("busy_done_state", 32'(busy), 32'd1);
        step();
        chk("done", 32'(done), 32'(exp1h));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("tdo_last", 32'(tdo), 32'(ed[0]));
        chk("ack_at_done", 32'(ack), 32'd0);
        shift_en = 1'b0;
    endtask

    initial begin
        logic seen;
        reset    = 1'b1;
        req      = '0;
        word     = '0;
        shift_en = 1'b0;
        abort    = 1'b0;

        tbl[0] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 1, 1'b0, 2'd0, 32'h0000_0001};
        tbl[1] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 1, 1'b0, 2'd1, 32'h0000_0002};
        tbl[2] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 1, 1'b0, 2'd2, 32'h0000_0004};
        tbl[3] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 1, 1'b0, 2'd3, 32'h0000_0008};
        tbl[4] = '{4'b1111, {32'h8, 32'h4, 32'h2, 32'h1}, 1, 1'b0, 2'd0, 32'h0000_0001};
        tbl[5] = '{4'b0001, {96'h0, 32'hDEAD_BEEF},       1, 1'b0, 2'd0, 32'hDEAD_BEEF};
        tbl[6] = '{4'b0001, {96'h0, 32'hA5A5_A5A5},       3, 1'b0, 2'd0, 32'hA5A5_A5A5};
        tbl[7] = '{4'b0001, {96'h0, 32'hC3C3_5A5A},       1, 1'b1, 2'd0, 32'hC3C3_5A5A};

        repeat (3) step();
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_req_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_xfer(tbl[v].req, tbl[v].word, tbl[v].period, tbl[v].drop, tbl[v].eg, tbl[v].ed);
        end
        req = 4'b0000;
        step();

        // Abort after the 10th bit, then requester 1 is served again in full.
        req  = 4'b0010;
        word = {32'h0, 32'h0, 32'h5540_00FF, 32'h0};
        step();
        chk("abort_mid_ack", 32'(ack), 32'b0010);
        shift_bits(32'h5540_00FF, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_mid_busy", 32'(busy), 32'd0);
        chk("abort_mid_done", 32'(done), 32'd0);
        chk("abort_mid_tdo", 32'(tdo), 32'd1);
        run_xfer(4'b0010, {32'h0, 32'h0, 32'h5540_00FF, 32'h0}, 1, 1'b0, 2'd1, 32'h5540_00FF);

        // Abort coincident with the final shift: no done, ptr stays at 1.
        req  = 4'b1111;
        word = {32'h0, 32'h8000_0001, 32'h0, 32'h0};
        step();
        chk("abort_last_ack", 32'(ack), 32'b0100);
        shift_bits(32'h8000_0001, 31);
        shift_en = 1'b1;
        abort    = 1'b1;
        step();
        shift_en = 1'b0;
        abort    = 1'b0;
        chk("abort_last_busy", 32'(busy), 32'd0);
        chk("abort_last_done", 32'(done), 32'd0);
        chk("abort_last_tdo", 32'(tdo), 32'd0);
        run_xfer(4'b1111, {32'h0, 32'h8000_0001, 32'h0, 32'h0}, 1, 1'b0, 2'd2, 32'h8000_0001);
        req = 4'b0000;

        // Abort in IDLE suppresses the grant for that cycle.
        req   = 4'b0001;
        word  = {96'h0, 32'hF00F_0FF0};
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_ack", 32'(ack), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        run_xfer(4'b0001, {96'h0, 32'hF00F_0FF0}, 1, 1'b0, 2'd0, 32'hF00F_0FF0);
        req = 4'b0000;

        // Reset at bit 20 discards the transfer.
        req  = 4'b0100;
        word = {32'h0, 32'h1234_5678, 64'h0};
        step();
        chk("rst_mid_ack", 32'(ack), 32'b0100);
        chk("rst_mid_grant", 32'(grant_id), 32'd2);
        req = 4'b0000;
        shift_bits(32'h1234_5678, 20);
        reset    = 1'b1;
        shift_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_tdo", 32'(tdo), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ack0", 32'(ack), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_grant_id", 32'(grant_id), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done != 4'b0000 || busy) seen = 1'b1;
        end
        shift_en = 1'b0;
        chk("rst_mid_quiet", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdo_word_scheduler.md
Name: tdo_word_scheduler

Overview:
Round-robin scheduler that shares one serial TDO path between NREQ requesters. Each requester offers one WIDTH-bit word. The block grants one requester, captures its word and shifts it out MSB first, one bit per shift_en cycle. It pulses a per-requester done when the last bit has gone out. It sits between the TAP controller (which supplies shift_en and abort) and the user/ID data-register sources.

Parameters:
NREQ, 4, number of requesters (>= 2)
WIDTH, 32, bits per word (>= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester level request; bit i belongs to requester i
word  in  NREQ*WIDTH  flattened words; word[i*WIDTH +: WIDTH] belongs to requester i
shift_en  in  1  advance one bit this cycle (TAP in Shift-DR)
abort  in  1  terminate current transfer (TAP left Shift-DR)
tdo  out  1  registered serial data
ack  out  NREQ  one-cycle pulse: word of requester i captured
done  out  NREQ  one-cycle pulse: all WIDTH bits of requester i shifted
busy  out  1  high whenever state != IDLE
grant_id  out  clog2(NREQ)  index of current or last granted requester

Behaviour:
- Reset state (all registered, effective the cycle after reset is high):
  - state=IDLE; tdo=0; ack=0; done=0; busy=0; grant_id=0.
  - ptr=NREQ-1, so requester 0 has first priority.
  - Reset mid-transfer discards the transfer with no done pulse.
- Priority order: reset > abort > normal operation.
- States: IDLE, SHIFT, DONE.
- IDLE, when |req:
  - g = first set req bit searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Next cycle: grant_id=g; shreg=word[g]; cnt=WIDTH; ack[g]=1 for exactly one cycle; state=SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT, when shift_en:
  - tdo <= shreg[WIDTH-1]; shreg <<= 1; cnt <= cnt-1.
  - If cnt==1: state <= DONE.
  - Without shift_en: tdo, shreg and cnt all hold.
- DONE (exactly one cycle):
  - done[grant_id]=1; ptr<=grant_id; state <= IDLE.
  - tdo holds the last bit; shift_en is ignored.
- Counter: cnt is clog2(WIDTH)+1 bits wide and never underflows.
- Timing:
  - The first bit appears on tdo the cycle after the first shift_en in SHIFT.
  - Minimum period is WIDTH+2 cycles per word (IDLE grant, WIDTH shifts, DONE).
  - Back-to-back grants are separated by one IDLE cycle.
- abort in SHIFT or DONE:
  - Next cycle state=IDLE; no done pulse; ptr unchanged; tdo holds.
  - The aborted requester stays eligible if it still requests.
  - abort in the same cycle as the final shift_en: abort wins, no done.
  - abort in IDLE: the grant is suppressed that cycle.
- After capture:
  - Dropping req or changing word has no effect; the transfer completes.
  - req is re-sampled only in IDLE.
- Pulse rules: ack and done are one-hot or zero and are never asserted in the same cycle.

Decomposition:
- Shared package tdo_sched_pkg: state enum (IDLE, SHIFT, DONE); localparam widths CNT_W=clog2(WIDTH)+1 and ID_W=clog2(NREQ).
- One sub-module: rr_arbiter (purely combinational).
  - Inputs: req, ptr. Outputs: grant index, any_req.
  - ptr and the rest of the sequential state stay in tdo_word_scheduler.

Test Plan:
1. Single word, continuous shift: reset; req=0001; word0=0xDEADBEEF; shift_en=1 continuously -> ack[0] pulses 1 cycle after req; tdo streams 1101_1110_1010_1101_1011_1110_1110_1111 MSB first; done[0] pulses at cycle 34; busy returns to 0.
2. Round-robin fairness: req=1111 held; words 0x1, 0x2, 0x4, 0x8 -> grant_id sequence 0,1,2,3,0; each done precedes the next ack; no requester granted twice in a row.
3. Gated shifting: shift_en high 1 cycle in 3; word=0xA5A5A5A5 -> tdo changes only the cycle after shift_en; done after exactly 32 shift_en pulses (about 96 cycles); no bit duplicated or dropped.
4. Abort mid-word: abort after the 10th shift -> IDLE next cycle, no done, busy=0; with req=0010 still high, requester 1 is re-granted and the full 32-bit word is re-sent.
5. Abort on the last bit: abort coincident with the 32nd shift_en -> no done pulse; the following grant follows round-robin order from the unchanged ptr.
6. Reset and input stability:
   - Reset asserted at bit 20 -> next cycle tdo=0, busy=0, ack=done=0.
   - Separate run: change word0 and drop req0 after ack -> the stream equals the originally captured word.
